// File: rtl/qddc.sv
// Quadrature down-converter: per-channel 3-stage CIC, decimate by 256, 16-bit output.
// Latency: out_valid rises 3 clocks after each decimation strobe (first at cycle 258).
// Backpressure: none; free-running on clk, exactly one output pair per 256 input pairs.

// One CIC decimator channel. The shared counter in the parent supplies the
// strobe and the comb-stage enables, so I and Q stay in lockstep.
module qddc_cic #(
  parameter int ISZ   = 14,
  parameter int OSZ   = 16,
  parameter int CICSZ = 38
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ISZ-1:0]   x,
  input  logic             strobe,
  input  logic             c2_en,
  input  logic             c3_en,
  input  logic             out_en,
  output logic [OSZ-1:0]   y
);

  logic [ISZ-1:0]   x_q,       x_d;
  logic [CICSZ-1:0] int1_q,    int1_d;
  logic [CICSZ-1:0] int2_q,    int2_d;
  logic [CICSZ-1:0] int3_q,    int3_d;
  logic [CICSZ-1:0] s_prev_q,  s_prev_d;
  logic [CICSZ-1:0] c1_q,      c1_d;
  logic [CICSZ-1:0] c1_prev_q, c1_prev_d;
  logic [CICSZ-1:0] c2_q,      c2_d;
  logic [CICSZ-1:0] c2_prev_q, c2_prev_d;
  logic [CICSZ-1:0] c3_q,      c3_d;
  logic [OSZ-1:0]   y_q,       y_d;
  logic [CICSZ-1:0] x_ext;
  logic             unused_trunc;

  // Sign-extend the registered input to the full CIC width.
  assign x_ext = {{(CICSZ-ISZ){x_q[ISZ-1]}}, x_q};

  // Low bits of the last comb stage are discarded by plain truncation.
  assign unused_trunc = ^c3_q[CICSZ-OSZ-1:0];

  // Integrators run every clock (modulo 2^CICSZ); comb stages advance once per decimated sample.
  always_comb begin
    x_d       = x;
    int1_d    = int1_q + x_ext;
    int2_d    = int2_q + int1_q;
    int3_d    = int3_q + int2_q;
    s_prev_d  = s_prev_q;
    c1_d      = c1_q;
    c1_prev_d = c1_prev_q;
    c2_d      = c2_q;
    c2_prev_d = c2_prev_q;
    c3_d      = c3_q;
    y_d       = y_q;

    if (strobe) begin
      c1_d     = int3_q - s_prev_q;
      s_prev_d = int3_q;
    end
    if (c2_en) begin
      c2_d      = c1_q - c1_prev_q;
      c1_prev_d = c1_q;
    end
    if (c3_en) begin
      c3_d      = c2_q - c2_prev_q;
      c2_prev_d = c2_q;
    end
    if (out_en) begin
      y_d = c3_q[CICSZ-1 -: OSZ];
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      int1_q    <= '0;
      int2_q    <= '0;
      int3_q    <= '0;
      s_prev_q  <= '0;
      c1_q      <= '0;
      c1_prev_q <= '0;
      c2_q      <= '0;
      c2_prev_q <= '0;
      c3_q      <= '0;
      y_q       <= '0;
    end else begin
      x_q       <= x_d;
      int1_q    <= int1_d;
      int2_q    <= int2_d;
      int3_q    <= int3_d;
      s_prev_q  <= s_prev_d;
      c1_q      <= c1_d;
      c1_prev_q <= c1_prev_d;
      c2_q      <= c2_d;
      c2_prev_q <= c2_prev_d;
      c3_q      <= c3_d;
      y_q       <= y_d;
    end
  end

  assign y = y_q;

endmodule

module qddc (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] in_i,
  input  logic [13:0] in_q,
  output logic [15:0] out_i,
  output logic [15:0] out_q,
  output logic        out_valid
);

  localparam int ISZ   = 14;
  localparam int OSZ   = 16;
  localparam int R     = 256;
  localparam int N     = 3;
  localparam int CNTW  = $clog2(R);
  localparam int CICSZ = ISZ + N * CNTW;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            c1_vld_q, c1_vld_d;
  logic            c2_vld_q, c2_vld_d;
  logic            c3_vld_q, c3_vld_d;
  logic            out_valid_q, out_valid_d;
  logic            strobe;

  // Decimation phase: strobe on the last count of each 256-clock frame.
  assign strobe = (cnt_q == CNTW'(R - 1));

  // Counter wraps naturally; the valid token walks down the comb pipeline behind each strobe.
  always_comb begin
    cnt_d       = cnt_q + CNTW'(1);
    c1_vld_d    = strobe;
    c2_vld_d    = c1_vld_q;
    c3_vld_d    = c2_vld_q;
    out_valid_d = c3_vld_q;
  end

  // Control registers; reset cancels any in-flight sample and restarts the cadence.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      c1_vld_q    <= 1'b0;
      c2_vld_q    <= 1'b0;
      c3_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      c1_vld_q    <= c1_vld_d;
      c2_vld_q    <= c2_vld_d;
      c3_vld_q    <= c3_vld_d;
      out_valid_q <= out_valid_d;
    end
  end

  qddc_cic #(.ISZ(ISZ), .OSZ(OSZ), .CICSZ(CICSZ)) u_cic_i (
    .clk    (clk),
    .reset  (reset),
    .x      (in_i),
    .strobe (strobe),
    .c2_en  (c1_vld_q),
    .c3_en  (c2_vld_q),
    .out_en (c3_vld_q),
    .y      (out_i)
  );

  qddc_cic #(.ISZ(ISZ), .OSZ(OSZ), .CICSZ(CICSZ)) u_cic_q (
    .clk    (clk),
    .reset  (reset),
    .x      (in_q),
    .strobe (strobe),
    .c2_en  (c1_vld_q),
    .c3_en  (c2_vld_q),
    .out_en (c3_vld_q),
    .y      (out_q)
  );

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_qddc.sv
// Testbench for qddc: scoreboard fed by a bit-true CIC reference, plus per-scenario checks.
// Latency: expects each output 3 clocks after the strobe edge (cycle 258 + 256m after reset).
// Backpressure: none; one stimulus pair is driven per clock.
module tb_qddc;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] in_i, in_q;
  logic [15:0] out_i, out_q;
  logic        out_valid;

  always #5 clk = ~clk;

  qddc dut (
    .clk       (clk),
    .reset     (reset),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  typedef struct {
    int          cyc;
    logic [15:0] i;
    logic [15:0] q;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = -1;
  int          m_cnt    = 0;
  int          valid_idx = 0;
  logic [15:0] held_i = '0, held_q = '0;
  logic [13:0] m_x  [2];
  logic [37:0] m_i1 [2];
  logic [37:0] m_i2 [2];
  logic [37:0] m_i3 [2];
  logic [37:0] m_s1 [2];
  logic [37:0] m_s2 [2];
  logic [37:0] m_s3 [2];

  // Reference model update for one clock edge with the inputs the DUT just sampled.
  task automatic model_edge(input logic rst, input logic [13:0] xi, input logic [13:0] xq);
    logic [37:0] s, d;
    logic [15:0] e [2];
    logic [13:0] xin [2];
    xin[0] = xi;
    xin[1] = xq;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_x[c] = '0; m_i1[c] = '0; m_i2[c] = '0; m_i3[c] = '0;
        m_s1[c] = '0; m_s2[c] = '0; m_s3[c] = '0;
      end
      sb.delete();
      held_i = '0; held_q = '0;
      cyc = -1; m_cnt = 0; valid_idx = 0;
    end else begin
      cyc++;
      if (m_cnt == 255) begin
        for (int c = 0; c < 2; c++) begin
          s = m_i3[c];
          // Third difference of the decimated integrator output, written directly.
          d = s - 38'd3 * m_s1[c] + 38'd3 * m_s2[c] - m_s3[c];
          e[c] = d[37:22];
          m_s3[c] = m_s2[c]; m_s2[c] = m_s1[c]; m_s1[c] = s;
        end
        sb.push_back('{cyc: cyc + 3, i: e[0], q: e[1]});
      end
      for (int c = 0; c < 2; c++) begin
        m_i3[c] = m_i3[c] + m_i2[c];
        m_i2[c] = m_i2[c] + m_i1[c];
        m_i1[c] = m_i1[c] + {{24{m_x[c][13]}}, m_x[c]};
        m_x[c]  = xin[c];
      end
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  // Drive one clock of stimulus, advance the model, then check the DUT against the scoreboard.
  task automatic step(input logic rst, input logic [13:0] xi, input logic [13:0] xq);
    logic exp_v;
    reset = rst; in_i = xi; in_q = xq;
    @(posedge clk);
    model_edge(rst, xi, xq);
    #1;
    exp_v = (sb.size() > 0 && sb[0].cyc == cyc);
    n_checks++;
    if (out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL sb_valid cyc=%0d: got %b want %b", cyc, out_valid, exp_v);
    end
    if (exp_v) begin
      held_i = sb[0].i; held_q = sb[0].q;
      void'(sb.pop_front());
      valid_idx++;
    end
    n_checks++;
    if (out_i !== held_i || out_q !== held_q) begin
      n_fail++;
      $display("FAIL sb_data cyc=%0d: got i=%h q=%h want i=%h q=%h", cyc, out_i, out_q, held_i, held_q);
    end
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 14'($urandom), 14'($urandom));
      n_checks++;
      if (out_valid !== 1'b0 || out_i !== 16'h0 || out_q !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d: got v=%b i=%h q=%h want 0", k, out_valid, out_i, out_q);
      end
    end
    step(1'b0, 14'($urandom), 14'($urandom));
    n_checks++;
    if (out_valid !== 1'b0 || out_i !== 16'h0 || out_q !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b i=%h q=%h want 0", out_valid, out_i, out_q);
    end
  endtask

  task automatic test_cadence();
    int nv = 0;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      step(1'b0, 14'($urandom), 14'($urandom));
      if (out_valid === 1'b1) begin
        n_checks++;
        if (k !== 258 + 256 * nv) begin
          n_fail++;
          $display("FAIL cadence_cycle: got %0d want %0d", k, 258 + 256 * nv);
        end
        nv++;
      end
    end
    n_checks++;
    if (nv !== 7) begin
      n_fail++;
      $display("FAIL cadence_count: got %0d want 7", nv);
    end
  endtask

  task automatic test_dc_full();
    int nchk = 0;
    do_reset();
    for (int k = 0; k < 2600; k++) begin
      step(1'b0, 14'h1FFF, 14'h2000);
      if (out_valid === 1'b1 && valid_idx >= 4) begin
        n_checks++;
        if (out_i !== 16'h7FFC || out_q !== 16'h8000) begin
          n_fail++;
          $display("FAIL dc_full: got i=%h q=%h want i=7ffc q=8000", out_i, out_q);
        end
        nchk++;
      end
    end
    n_checks++;
    if (nchk !== 7) begin
      n_fail++;
      $display("FAIL dc_full_count: got %0d want 7", nchk);
    end
  endtask

  task automatic test_channel_indep();
    int pv = 0;
    do_reset();
    for (int k = 0; k < 4281; k++) begin
      step(1'b0, (k < 3000) ? 14'd1000 : 14'd0, 14'h3C18);
      if (out_valid === 1'b1 && valid_idx >= 4) begin
        n_checks++;
        if (out_q !== 16'hF060) begin
          n_fail++;
          $display("FAIL indep_q k=%0d: got %h want f060", k, out_q);
        end
        if (k < 3000) begin
          n_checks++;
          if (out_i !== 16'h0FA0) begin
            n_fail++;
            $display("FAIL indep_i_pre k=%0d: got %h want 0fa0", k, out_i);
          end
        end
      end
      if (out_valid === 1'b1 && k >= 3000) begin
        pv++;
        if (pv >= 4) begin
          n_checks++;
          if (out_i !== 16'h0000) begin
            n_fail++;
            $display("FAIL indep_i_post pv=%0d: got %h want 0000", pv, out_i);
          end
        end
      end
    end
    n_checks++;
    if (pv !== 5) begin
      n_fail++;
      $display("FAIL indep_post_count: got %0d want 5", pv);
    end
  endtask

  task automatic test_wrap();
    int nchk = 0;
    do_reset();
    for (int k = 0; k < 20000; k++) begin
      step(1'b0, 14'h1FFF, 14'($urandom));
      if (out_valid === 1'b1 && valid_idx >= 4) begin
        n_checks++;
        if (out_i !== 16'h7FFC) begin
          n_fail++;
          $display("FAIL wrap_i k=%0d: got %h want 7ffc", k, out_i);
        end
        nchk++;
      end
    end
    n_checks++;
    if (nchk < 70) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want >=70", nchk);
    end
  endtask

  // Reset lands one edge after a strobe (edge 1023), so the output due at 1026 must vanish.
  task automatic test_mid_reset();
    int first = -1;
    do_reset();
    for (int k = 0; k < 1024; k++) step(1'b0, 14'($urandom), 14'($urandom));
    step(1'b1, 14'($urandom), 14'($urandom));
    for (int j = 1; j <= 300; j++) begin
      step(1'b0, 14'($urandom), 14'($urandom));
      if (j == 2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_cancel: got %b want 0", out_valid);
        end
      end
      if (first < 0 && out_valid === 1'b1) first = j;
      if (first < 0 && j < 259) begin
        n_checks++;
        if (out_i !== 16'h0 || out_q !== 16'h0) begin
          n_fail++;
          $display("FAIL midrst_zero j=%0d: got i=%h q=%h want 0", j, out_i, out_q);
        end
      end
    end
    n_checks++;
    if (first !== 259) begin
      n_fail++;
      $display("FAIL midrst_first_valid: got %0d want 259", first);
    end
  endtask

  initial begin
    reset = 1'b1; in_i = '0; in_q = '0;
    test_reset();
    test_cadence();
    test_dc_full();
    test_channel_indep();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
